gearbox_serializer: RTL and testbench

Parametrised wide-to-narrow serializer for the camera/VGA output path. It splits each IN_WIDTH input word into RATIO = IN_WIDTH/OUT_WIDTH output beats over a valid/ready stream. The integer ratio need not be a power of two. Beat order is selectable (LSB-first or MSB-first). A one-word skid register lets the next word be accepted while the current one drains, so output is gap-free at one beat per cycle. A per-word last flag travels with the final beat.

---
 rtl/gearbox_serializer.sv | 79 +++++++
 tb/tb_gearbox_serializer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gearbox_serializer.sv
// gearbox_serializer: splits IN_WIDTH words into RATIO OUT_WIDTH beats, with a
// one-word hold register so the next word can be accepted while the current one drains.
module gearbox_serializer #(
  parameter int IN_WIDTH  = 64,
  parameter int OUT_WIDTH = 8,
  parameter bit MSB_FIRST = 0,
  localparam int RATIO = IN_WIDTH / OUT_WIDTH,
  localparam int BW = $clog2(RATIO)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_last,
  output logic [BW-1:0]        out_beat
);
  if (RATIO < 2 || IN_WIDTH % OUT_WIDTH != 0) begin : g_bad_ratio
    $error("gearbox_serializer: IN_WIDTH must be a multiple of OUT_WIDTH with ratio >= 2");
  end
  logic [IN_WIDTH-1:0] sh, hold;
  logic                sh_valid, sh_last, hold_valid, hold_last;
  logic [BW-1:0]       beat;
  logic                acc, pop, end_beat, fin;
  assign end_beat  = beat == BW'(RATIO - 1);
  assign acc       = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign fin       = pop & end_beat;
  assign in_ready  = !hold_valid;
  assign out_valid = sh_valid;
  assign out_beat  = beat;
  assign out_last  = sh_valid & sh_last & end_beat;
  assign out_data  = MSB_FIRST ? sh[IN_WIDTH-1 -: OUT_WIDTH] : sh[OUT_WIDTH-1:0];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh         <= '0;
      hold       <= '0;
      sh_valid   <= 1'b0;
      sh_last    <= 1'b0;
      hold_valid <= 1'b0;
      hold_last  <= 1'b0;
      beat       <= '0;
    end else if (pop && !fin) begin
      sh   <= MSB_FIRST ? sh << OUT_WIDTH : sh >> OUT_WIDTH;
      beat <= beat + BW'(1);
      if (acc) begin
        hold       <= in_data;
        hold_last  <= in_last;
        hold_valid <= 1'b1;
      end
    end else if (fin || !sh_valid) begin
      beat <= '0;
      if (hold_valid) begin
        sh         <= hold;
        sh_last    <= hold_last;
        sh_valid   <= 1'b1;
        hold_valid <= acc;
        if (acc) begin
          hold      <= in_data;
          hold_last <= in_last;
        end
      end else if (acc) begin
        sh       <= in_data;
        sh_last  <= in_last;
        sh_valid <= 1'b1;
      end else begin
        sh_valid <= 1'b0;
      end
    end else if (acc) begin
      hold       <= in_data;
      hold_last  <= in_last;
      hold_valid <= 1'b1;
    end
  end
endmodule

// File: tb/tb_gearbox_serializer.sv
// tb_gearbox_serializer: directed checks on three configurations (24/8 LSB-first,
// 24/8 MSB-first, 40/8 LSB-first) sharing one clock and reset.
module tb_gearbox_serializer;
  logic clk = 0;
  logic rst_n = 0;
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;

  logic        a_valid = 0, a_ready, a_last = 0, a_ovalid, a_oready = 1, a_olast;
  logic [23:0] a_data = '0;
  logic [7:0]  a_odata;
  logic [1:0]  a_beat;
  logic        b_valid = 0, b_ready, b_last = 0, b_ovalid, b_oready = 1, b_olast;
  logic [23:0] b_data = '0;
  logic [7:0]  b_odata;
  logic [1:0]  b_beat;
  logic        c_valid = 0, c_ready, c_last = 0, c_ovalid, c_oready = 1, c_olast;
  logic [39:0] c_data = '0;
  logic [7:0]  c_odata;
  logic [2:0]  c_beat;

  gearbox_serializer #(.IN_WIDTH(24), .OUT_WIDTH(8), .MSB_FIRST(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_ready(a_ready), .in_data(a_data),
    .in_last(a_last), .out_valid(a_ovalid), .out_ready(a_oready), .out_data(a_odata),
    .out_last(a_olast), .out_beat(a_beat));
  gearbox_serializer #(.IN_WIDTH(24), .OUT_WIDTH(8), .MSB_FIRST(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_ready(b_ready), .in_data(b_data),
    .in_last(b_last), .out_valid(b_ovalid), .out_ready(b_oready), .out_data(b_odata),
    .out_last(b_olast), .out_beat(b_beat));
  gearbox_serializer #(.IN_WIDTH(40), .OUT_WIDTH(8), .MSB_FIRST(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_valid), .in_ready(c_ready), .in_data(c_data),
    .in_last(c_last), .out_valid(c_ovalid), .out_ready(c_oready), .out_data(c_odata),
    .out_last(c_olast), .out_beat(c_beat));

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if (a_ovalid !== 0 || a_odata !== 8'h00 || a_olast !== 0 || a_beat !== 2'd0 || a_ready !== 1) begin
      errors++;
      $display("FAIL reset got v=%b d=%h l=%b b=%0d r=%b want v=0 d=00 l=0 b=0 r=1",
               a_ovalid, a_odata, a_olast, a_beat, a_ready);
    end
    rst_n = 1;
  endtask

  task automatic test_lsb_single;
    logic [7:0] exp [3] = '{8'hC3, 8'hB2, 8'hA1};
    @(negedge clk);
    a_valid = 1; a_data = 24'hA1B2C3; a_last = 1; a_oready = 1;
    @(negedge clk);
    a_valid = 0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if (a_ovalid !== 1 || a_odata !== exp[k] || a_beat !== 2'(k) || a_olast !== (k == 2)) begin
        errors++;
        $display("FAIL lsb_beat%0d got v=%b d=%h b=%0d l=%b want v=1 d=%h b=%0d l=%b",
                 k, a_ovalid, a_odata, a_beat, a_olast, exp[k], k, k == 2);
      end
    end
    @(negedge clk);
    checks++;
    if (a_ovalid !== 0) begin
      errors++;
      $display("FAIL lsb_idle got v=%b want v=0", a_ovalid);
    end
  endtask

  task automatic test_msb_single;
    logic [7:0] exp [3] = '{8'hA1, 8'hB2, 8'hC3};
    @(negedge clk);
    b_valid = 1; b_data = 24'hA1B2C3; b_last = 1; b_oready = 1;
    @(negedge clk);
    b_valid = 0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if (b_ovalid !== 1 || b_odata !== exp[k] || b_beat !== 2'(k) || b_olast !== (k == 2)) begin
        errors++;
        $display("FAIL msb_beat%0d got v=%b d=%h b=%0d l=%b want v=1 d=%h b=%0d l=%b",
                 k, b_ovalid, b_odata, b_beat, b_olast, exp[k], k, k == 2);
      end
    end
    @(negedge clk);
    checks++;
    if (b_ovalid !== 0) begin
      errors++;
      $display("FAIL msb_idle got v=%b want v=0", b_ovalid);
    end
  endtask

  task automatic test_streaming;
    logic [23:0] words [3] = '{24'h030201, 24'h060504, 24'h090807};
    int idx = 0;
    a_oready = 1; a_last = 0;
    for (int k = 0; k <= 9; k++) begin
      @(negedge clk);
      if (k > 0) begin
        checks++;
        if (a_ovalid !== 1 || a_odata !== 8'(k)) begin
          errors++;
          $display("FAIL stream_beat%0d got v=%b d=%h want v=1 d=%h", k, a_ovalid, a_odata, 8'(k));
        end
      end
      if (idx < 3) begin
        a_valid = 1; a_data = words[idx];
        if (a_ready) idx++;
      end else a_valid = 0;
    end
    @(negedge clk);
    checks++;
    if (a_ovalid !== 0) begin
      errors++;
      $display("FAIL stream_idle got v=%b want v=0", a_ovalid);
    end
  endtask

  task automatic test_backpressure;
    @(negedge clk);
    a_valid = 1; a_data = 24'h030201; a_last = 0; a_oready = 1;
    @(negedge clk);
    checks++;
    if (a_odata !== 8'h01 || a_beat !== 2'd0 || a_ready !== 1) begin
      errors++;
      $display("FAIL bp_first got d=%h b=%0d r=%b want d=01 b=0 r=1", a_odata, a_beat, a_ready);
    end
    a_data = 24'h060504;
    @(negedge clk);
    a_data = 24'h090807;
    a_oready = 0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (a_ovalid !== 1 || a_odata !== 8'h02 || a_beat !== 2'd1 || a_ready !== 0) begin
        errors++;
        $display("FAIL bp_stall%0d got v=%b d=%h b=%0d r=%b want v=1 d=02 b=1 r=0",
                 i, a_ovalid, a_odata, a_beat, a_ready);
      end
    end
    a_oready = 1;
    @(negedge clk);
    checks++;
    if (a_odata !== 8'h03 || a_ready !== 0) begin
      errors++;
      $display("FAIL bp_third_blocked got d=%h r=%b want d=03 r=0", a_odata, a_ready);
    end
    @(negedge clk);
    checks++;
    if (a_odata !== 8'h04 || a_beat !== 2'd0 || a_ready !== 1) begin
      errors++;
      $display("FAIL bp_after_fin got d=%h b=%0d r=%b want d=04 b=0 r=1", a_odata, a_beat, a_ready);
    end
    for (int d = 5; d <= 9; d++) begin
      @(negedge clk);
      if (d == 5) a_valid = 0;
      checks++;
      if (a_ovalid !== 1 || a_odata !== 8'(d)) begin
        errors++;
        $display("FAIL bp_seq%0d got v=%b d=%h want v=1 d=%h", d, a_ovalid, a_odata, 8'(d));
      end
    end
    @(negedge clk);
    checks++;
    if (a_ovalid !== 0) begin
      errors++;
      $display("FAIL bp_idle got v=%b want v=0", a_ovalid);
    end
  endtask

  task automatic test_reset_mid_word;
    logic [7:0] exp [3] = '{8'h33, 8'h22, 8'h11};
    @(negedge clk);
    a_valid = 1; a_data = 24'hA1B2C3; a_last = 1; a_oready = 1;
    @(negedge clk);
    a_valid = 0;
    @(negedge clk);
    checks++;
    if (a_odata !== 8'hB2 || a_beat !== 2'd1) begin
      errors++;
      $display("FAIL rst_pre got d=%h b=%0d want d=b2 b=1", a_odata, a_beat);
    end
    #2 rst_n = 0;
    #1;
    checks++;
    if (a_ovalid !== 0 || a_odata !== 8'h00 || a_olast !== 0 || a_beat !== 2'd0 || a_ready !== 1) begin
      errors++;
      $display("FAIL rst_async got v=%b d=%h l=%b b=%0d r=%b want v=0 d=00 l=0 b=0 r=1",
               a_ovalid, a_odata, a_olast, a_beat, a_ready);
    end
    @(negedge clk);
    rst_n = 1;
    a_valid = 1; a_data = 24'h112233; a_last = 0;
    @(negedge clk);
    a_valid = 0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if (a_ovalid !== 1 || a_odata !== exp[k] || a_beat !== 2'(k) || a_olast !== 0) begin
        errors++;
        $display("FAIL rst_after_beat%0d got v=%b d=%h b=%0d l=%b want v=1 d=%h b=%0d l=0",
                 k, a_ovalid, a_odata, a_beat, a_olast, exp[k], k);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_ratio5;
    logic [39:0] words [2] = '{40'h0504030201, 40'h0A09080706};
    logic        lasts [2] = '{1'b0, 1'b1};
    int idx = 0;
    c_oready = 1;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      if (k > 0) begin
        checks++;
        if (c_ovalid !== 1 || c_odata !== 8'(k) || c_beat !== 3'((k - 1) % 5) || c_olast !== (k == 10)) begin
          errors++;
          $display("FAIL r5_beat%0d got v=%b d=%h b=%0d l=%b want v=1 d=%h b=%0d l=%b",
                   k, c_ovalid, c_odata, c_beat, c_olast, 8'(k), (k - 1) % 5, k == 10);
        end
      end
      if (idx < 2) begin
        c_valid = 1; c_data = words[idx]; c_last = lasts[idx];
        if (c_ready) idx++;
      end else c_valid = 0;
    end
    @(negedge clk);
    checks++;
    if (c_ovalid !== 0 || c_olast !== 0) begin
      errors++;
      $display("FAIL r5_idle got v=%b l=%b want v=0 l=0", c_ovalid, c_olast);
    end
  endtask

  initial begin
    test_reset;
    test_lsb_single;
    test_msb_single;
    test_streaming;
    test_backpressure;
    test_reset_mid_word;
    test_ratio5;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
